// File: rtl/serdes_tx_seq.sv
// Sequencer and symbol scheduler for a group of 10:1 OSERDES transmit lanes.
// Holds serializers in reset until lock, trains the link, then streams upstream words.
module serdes_tx_seq #(
    parameter int          LANES        = 3,
    parameter int          RST_CYCLES   = 16,
    parameter int          TRAIN_CYCLES = 64,
    parameter logic [9:0]  IDLE_SYM     = 10'h354,
    parameter logic [9:0]  TRAIN_SYM    = 10'h2AB
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_locked,
    input  logic                  i_enable,
    input  logic [10*LANES-1:0]   i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_serdes_reset,
    output logic [10*LANES-1:0]   o_data,
    output logic [1:0]            o_state,
    output logic                  o_underflow
);

    localparam int CNT_MAX = (RST_CYCLES > TRAIN_CYCLES) ? RST_CYCLES : TRAIN_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0]       RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]       TRAIN_LAST = CW'(TRAIN_CYCLES - 1);
    localparam logic [CW-1:0]       CNT_SAT    = {CW{1'b1}};
    localparam logic [10*LANES-1:0] IDLE_WORD  = {LANES{IDLE_SYM}};
    localparam logic [10*LANES-1:0] TRAIN_WORD = {LANES{TRAIN_SYM}};

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_WAIT  = 2'd1,
        ST_TRAIN = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;

    // Saturating increment: the counter holds at all-ones rather than wrapping.
    function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
        if (c == CNT_SAT) begin
            return c;
        end else begin
            return c + CW'(1);
        end
    endfunction

    assign o_state = state_r;
    assign o_ready = (state_r == ST_RUN);

    // Sequencer FSM; loss of lock overrides every state, enable and terminal count.
    always_ff @(posedge clk) begin
        if (reset || !i_locked) begin
            state_r        <= ST_RESET;
            cnt_r          <= '0;
            o_serdes_reset <= 1'b1;
            o_data         <= IDLE_WORD;
            o_underflow    <= 1'b0;
        end else begin
            o_underflow <= 1'b0;
            case (state_r)
                ST_RESET: begin
                    o_data <= IDLE_WORD;
                    if (cnt_r == RST_LAST) begin
                        state_r        <= ST_WAIT;
                        o_serdes_reset <= 1'b0;
                        cnt_r          <= '0;
                    end else begin
                        o_serdes_reset <= 1'b1;
                        cnt_r          <= cnt_inc(cnt_r);
                    end
                end
                ST_WAIT: begin
                    o_serdes_reset <= 1'b0;
                    cnt_r          <= '0;
                    if (i_enable) begin
                        state_r <= ST_TRAIN;
                        o_data  <= TRAIN_WORD;
                    end else begin
                        o_data  <= IDLE_WORD;
                    end
                end
                ST_TRAIN: begin
                    o_serdes_reset <= 1'b0;
                    if (!i_enable) begin
                        state_r <= ST_WAIT;
                        cnt_r   <= '0;
                        o_data  <= IDLE_WORD;
                    end else if (cnt_r == TRAIN_LAST) begin
                        // Idle on the first RUN cycle keeps training exactly TRAIN_CYCLES long.
                        state_r <= ST_RUN;
                        cnt_r   <= '0;
                        o_data  <= IDLE_WORD;
                    end else begin
                        cnt_r   <= cnt_inc(cnt_r);
                        o_data  <= TRAIN_WORD;
                    end
                end
                ST_RUN: begin
                    o_serdes_reset <= 1'b0;
                    // o_ready is high here, so the offered word is taken even on the exit cycle.
                    if (i_valid) begin
                        o_data      <= i_data;
                    end else begin
                        o_data      <= IDLE_WORD;
                        o_underflow <= 1'b1;
                    end
                    if (!i_enable) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r        <= ST_RESET;
                    cnt_r          <= '0;
                    o_serdes_reset <= 1'b1;
                    o_data         <= IDLE_WORD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serdes_tx_seq.sv
// Self-checking bench for serdes_tx_seq: reset hold, lock count, training, RUN scoreboard, aborts.
module tb_serdes_tx_seq;

    localparam logic [29:0] IDLE3  = {3{10'h354}};
    localparam logic [29:0] TRAIN3 = {3{10'h2AB}};

    logic        clk = 1'b0;
    logic        reset;
    logic        i_locked;
    logic        i_enable;
    logic [29:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic        o_serdes_reset;
    logic [29:0] o_data;
    logic [1:0]  o_state;
    logic        o_underflow;

    int n_checks = 0;
    int n_fail   = 0;
    int gaps_exp = 0;
    int uf_seen  = 0;

    logic [29:0] exp_data_q[$];
    logic        exp_uf_q[$];

    always #5 clk = ~clk;

    serdes_tx_seq dut (
        .clk            (clk),
        .reset          (reset),
        .i_locked       (i_locked),
        .i_enable       (i_enable),
        .i_data         (i_data),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_serdes_reset (o_serdes_reset),
        .o_data         (o_data),
        .o_state        (o_state),
        .o_underflow    (o_underflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic [1:0] st, input logic sr,
                              input logic rdy, input logic [29:0] d);
        check_eq({tag, "_state"}, 32'(o_state), 32'(st));
        check_eq({tag, "_sreset"}, 32'(o_serdes_reset), 32'(sr));
        check_eq({tag, "_ready"}, 32'(o_ready), 32'(rdy));
        check_eq({tag, "_data"}, 32'(o_data), 32'(d));
        check_eq({tag, "_uflow"}, 32'(o_underflow), 32'd0);
    endtask

    // One RUN cycle: expectation is queued at drive time and compared after the edge.
    task automatic run_cycle(input logic v, input logic [29:0] d);
        i_valid = v;
        i_data  = d;
        exp_data_q.push_back(v ? d : IDLE3);
        exp_uf_q.push_back(!v);
        if (!v) gaps_exp++;
        check_eq("run_ready", 32'(o_ready), 32'd1);
        tick();
        check_eq("run_data", 32'(o_data), 32'(exp_data_q.pop_front()));
        check_eq("run_uflow", 32'(o_underflow), 32'(exp_uf_q.pop_front()));
        if (o_underflow) uf_seen++;
    endtask

    task automatic lock_count(input string tag);
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16) check_ctrl(tag, 2'd0, 1'b1, 1'b0, IDLE3);
            else        check_ctrl({tag, "_done"}, 2'd1, 1'b0, 1'b0, IDLE3);
        end
    endtask

    initial begin
        reset    = 1'b1;
        i_locked = 1'b0;
        i_enable = 1'b0;
        i_valid  = 1'b0;
        i_data   = 30'd0;
        repeat (3) tick();
        check_ctrl("in_reset", 2'd0, 1'b1, 1'b0, IDLE3);
        reset = 1'b0;

        for (int k = 0; k < 100; k++) begin
            tick();
            check_ctrl("unlocked", 2'd0, 1'b1, 1'b0, IDLE3);
        end

        // Partial count, glitch of lock, then a full 16-cycle count.
        i_locked = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_ctrl("partial", 2'd0, 1'b1, 1'b0, IDLE3);
        end
        i_locked = 1'b0;
        tick();
        check_ctrl("glitch", 2'd0, 1'b1, 1'b0, IDLE3);
        i_locked = 1'b1;
        lock_count("lock1");

        for (int k = 0; k < 3; k++) begin
            tick();
            check_ctrl("wait", 2'd1, 1'b0, 1'b0, IDLE3);
        end

        // Abort training when the counter is at 30.
        i_enable = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            check_ctrl("train_a", 2'd2, 1'b0, 1'b0, TRAIN3);
        end
        i_enable = 1'b0;
        tick();
        check_ctrl("train_abort", 2'd1, 1'b0, 1'b0, IDLE3);

        i_enable = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            check_ctrl("train_b", 2'd2, 1'b0, 1'b0, TRAIN3);
        end
        tick();
        check_ctrl("run_entry", 2'd3, 1'b0, 1'b1, IDLE3);

        // Stream words 1..16 with two-cycle valid gaps between them.
        for (int w = 1; w <= 16; w++) begin
            run_cycle(1'b1, 30'(w));
            if (w < 16) begin
                run_cycle(1'b0, 30'h3FFF_FFFF);
                run_cycle(1'b0, 30'h3FFF_FFFF);
            end
        end
        check_eq("uflow_count", 32'(uf_seen), 32'(gaps_exp));

        // Enable drop in RUN still accepts the word offered that cycle.
        i_enable = 1'b0;
        run_cycle(1'b1, 30'h2AAA_AAAA);
        check_eq("run_exit_state", 32'(o_state), 32'd1);
        check_eq("run_exit_ready", 32'(o_ready), 32'd0);
        i_valid = 1'b0;
        tick();
        check_ctrl("after_exit", 2'd1, 1'b0, 1'b0, IDLE3);

        i_enable = 1'b1;
        repeat (65) tick();
        check_ctrl("rerun", 2'd3, 1'b0, 1'b1, IDLE3);

        // Lock loss during RUN with valid data offered.
        i_valid  = 1'b1;
        i_data   = 30'h155;
        i_locked = 1'b0;
        tick();
        check_ctrl("lock_loss", 2'd0, 1'b1, 1'b0, IDLE3);
        i_valid  = 1'b0;
        i_locked = 1'b1;
        lock_count("lock2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
